// File: rtl/reg_bank_wb_pkg.sv
// Shared constants and types for the write-back register bank.
// Destination-select codes and the fixed architectural register indices.
package reg_bank_wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;
    localparam int SP_RESET = 227;

    typedef enum logic [1:0] {
        REGDST_RT = 2'b00,
        REGDST_RD = 2'b01,
        REGDST_RA = 2'b10,
        REGDST_SP = 2'b11
    } regdst_e;

endpackage

// File: rtl/reg_bank_wb_if.sv
// Write-back / operand-latch bus between the datapath and the register bank.
// master drives the instruction fields and write-back word; slave returns reads and latches.
interface reg_bank_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              reg_write;
    logic [1:0]        reg_dst;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] write_data;
    logic              a_load;
    logic              b_load;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic [ADDR_W-1:0] wr_addr;

    modport master (
        output reg_write, reg_dst, rs, rt, rd, write_data, a_load, b_load,
        input  rs_data, rt_data, a_out, b_out, wr_addr
    );

    modport slave (
        input  reg_write, reg_dst, rs, rt, rd, write_data, a_load, b_load,
        output rs_data, rt_data, a_out, b_out, wr_addr
    );

endinterface

// File: rtl/reg_bank_wb_dst_sel.sv
// Destination register decoder: rt / rd / $ra / $sp selected by the 2-bit reg_dst code.
// Latency: purely combinational.
// Backpressure: none, the decode is always valid.
module reg_dst_sel
    import reg_bank_wb_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  regdst_e           reg_dst,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    output logic [ADDR_W-1:0] wr_addr
);

    always_comb begin
        wr_addr = rt;
        case (reg_dst)
            REGDST_RT: wr_addr = rt;
            REGDST_RD: wr_addr = rd;
            REGDST_RA: wr_addr = ADDR_W'(REG_RA);
            REGDST_SP: wr_addr = ADDR_W'(REG_SP);
            default:   wr_addr = rt;
        endcase
    end

endmodule

// File: rtl/reg_bank_wb.sv
// Write-back register bank with read-old ports and write-first bypassed A/B operand latches.
// Latency: rs_data/rt_data combinational; write visible on reads next cycle, in A/B on the same edge.
// Backpressure: none, every write and load completes on the edge it is presented.
module reg_bank_wb
    import reg_bank_wb_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(227)
) (
    input  logic         clk,
    input  logic         reset_n,
    reg_bank_wb_if.slave bus
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    logic [DATA_W-1:0] rs_rd;
    logic [DATA_W-1:0] rt_rd;
    logic              byp_a;
    logic              byp_b;
    logic [DATA_W-1:0] a_nxt;
    logic [DATA_W-1:0] b_nxt;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    reg_dst_sel #(
        .ADDR_W (ADDR_W)
    ) u_dst_sel (
        .reg_dst (regdst_e'(bus.reg_dst)),
        .rt      (bus.rt),
        .rd      (bus.rd),
        .wr_addr (wr_addr)
    );

    // Writes to $zero are squashed here so neither the array nor the bypass ever sees them.
    assign wr_en = bus.reg_write && (wr_addr != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == REG_SP) ? SP_RESET : '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= bus.write_data;
        end
    end

    assign rs_rd = (bus.rs == '0) ? '0 : regs[bus.rs];
    assign rt_rd = (bus.rt == '0) ? '0 : regs[bus.rt];

    // Bypass lets an operand latched on the write edge see the word being written.
    assign byp_a = wr_en && (wr_addr == bus.rs);
    assign byp_b = wr_en && (wr_addr == bus.rt);
    assign a_nxt = byp_a ? bus.write_data : rs_rd;
    assign b_nxt = byp_b ? bus.write_data : rt_rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (bus.a_load) a_q <= a_nxt;
            if (bus.b_load) b_q <= b_nxt;
        end
    end

    assign bus.rs_data = rs_rd;
    assign bus.rt_data = rt_rd;
    assign bus.a_out   = a_q;
    assign bus.b_out   = b_q;
    assign bus.wr_addr = wr_addr;

endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed bench for reg_bank_wb: expectations queued with each stimulus step, drained after it settles.
module tb_reg_bank_wb;

    localparam int SEL_RS = 0;
    localparam int SEL_RT = 1;
    localparam int SEL_A  = 2;
    localparam int SEL_B  = 3;
    localparam int SEL_WA = 4;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    exp_t sbq[$];

    reg_bank_wb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_bank_wb #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .SP_RESET (32'd227)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_RS:  return bus.rs_data;
            SEL_RT:  return bus.rt_data;
            SEL_A:   return bus.a_out;
            SEL_B:   return bus.b_out;
            default: return 32'(bus.wr_addr);
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 2'b00;
        bus.rs         = '0;
        bus.rt         = '0;
        bus.rd         = '0;
        bus.write_data = '0;
        bus.a_load     = 1'b0;
        bus.b_load     = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle();

        // Async reset asserted mid-cycle, before any clock edge.
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        push("rst_a", SEL_A, 32'h0);
        push("rst_b", SEL_B, 32'h0);
        drain();
        bus.rs = 5'd29;
        bus.rt = 5'd5;
        #1;
        push("rst_sp", SEL_RS, 32'd227);
        push("rst_r5", SEL_RT, 32'h0);
        push("rst_wa_rt", SEL_WA, 32'd5);
        drain();
        tick();
        tick();
        reset_n = 1'b1;

        // Write rd=8 and read it back next cycle; read is old during the write cycle.
        bus.reg_dst    = 2'b01;
        bus.rd         = 5'd8;
        bus.rs         = 5'd8;
        bus.write_data = 32'hDEADBEEF;
        bus.reg_write  = 1'b1;
        #1;
        push("wa_rd", SEL_WA, 32'd8);
        push("r8_old", SEL_RS, 32'h0);
        drain();
        tick();
        bus.reg_write = 1'b0;
        #1;
        push("r8_new", SEL_RS, 32'hDEADBEEF);
        drain();

        // $zero write is dropped and reads/loads of index 0 give 0.
        bus.reg_dst    = 2'b00;
        bus.rt         = 5'd0;
        bus.rs         = 5'd0;
        bus.write_data = 32'h1234;
        bus.reg_write  = 1'b1;
        bus.a_load     = 1'b1;
        bus.b_load     = 1'b1;
        tick();
        idle();
        #1;
        push("zero_rt", SEL_RT, 32'h0);
        push("zero_rs", SEL_RS, 32'h0);
        push("zero_a", SEL_A, 32'h0);
        push("zero_b", SEL_B, 32'h0);
        drain();

        // Seed r9 with 0x11, then bypass 0x55 into both latches on the same edge.
        bus.reg_dst    = 2'b01;
        bus.rd         = 5'd9;
        bus.write_data = 32'h11;
        bus.reg_write  = 1'b1;
        tick();
        bus.write_data = 32'h55;
        bus.rs         = 5'd9;
        bus.rt         = 5'd9;
        bus.a_load     = 1'b1;
        bus.b_load     = 1'b1;
        #1;
        push("byp_rs_old", SEL_RS, 32'h11);
        push("byp_rt_old", SEL_RT, 32'h11);
        drain();
        tick();
        push("byp_a", SEL_A, 32'h55);
        push("byp_b", SEL_B, 32'h55);
        push("byp_rs_new", SEL_RS, 32'h55);
        drain();

        // Load from the array while writing an unrelated register: no false bypass.
        bus.rs         = 5'd8;
        bus.rt         = 5'd9;
        bus.rd         = 5'd10;
        bus.write_data = 32'h77;
        tick();
        idle();
        #1;
        push("ld_a", SEL_A, 32'hDEADBEEF);
        push("ld_b", SEL_B, 32'h55);
        drain();

        // Fixed destinations ignore rt/rd.
        bus.rt         = 5'd3;
        bus.rd         = 5'd4;
        bus.reg_dst    = 2'b10;
        bus.write_data = 32'h40;
        bus.reg_write  = 1'b1;
        #1;
        push("wa_ra", SEL_WA, 32'd31);
        drain();
        tick();
        bus.reg_dst    = 2'b11;
        bus.write_data = 32'hE0;
        #1;
        push("wa_sp", SEL_WA, 32'd29);
        drain();
        tick();
        bus.reg_write = 1'b0;
        bus.rs        = 5'd31;
        bus.rt        = 5'd29;
        #1;
        push("ra_val", SEL_RS, 32'h40);
        push("sp_val", SEL_RT, 32'hE0);
        drain();
        bus.rs = 5'd3;
        bus.rt = 5'd4;
        #1;
        push("r3_kept", SEL_RS, 32'h0);
        push("r4_kept", SEL_RT, 32'h0);
        drain();
        bus.rs = 5'd10;
        #1;
        push("r10_val", SEL_RS, 32'h77);
        drain();

        // Hold: latches keep their value while their source registers are rewritten.
        bus.rs      = 5'd8;
        bus.rt      = 5'd9;
        bus.reg_dst = 2'b01;
        for (int k = 0; k < 4; k++) begin
            bus.rd         = (k % 2 == 1) ? 5'd9 : 5'd8;
            bus.write_data = 32'hA000 + 32'(k);
            bus.reg_write  = 1'b1;
            tick();
            push("hold_a", SEL_A, 32'hDEADBEEF);
            push("hold_b", SEL_B, 32'h55);
            drain();
        end
        bus.reg_write = 1'b0;
        #1;
        push("hold_r8", SEL_RS, 32'hA002);
        push("hold_r9", SEL_RT, 32'hA003);
        drain();

        // Reset mid-write: pending write lost, array and latches back to reset values.
        bus.rt         = 5'd29;
        bus.rd         = 5'd8;
        bus.write_data = 32'hCAFE;
        bus.reg_write  = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        push("mid_a", SEL_A, 32'h0);
        push("mid_b", SEL_B, 32'h0);
        push("mid_r8", SEL_RS, 32'h0);
        push("mid_sp", SEL_RT, 32'd227);
        drain();
        tick();
        push("rstlow_r8", SEL_RS, 32'h0);
        drain();
        idle();
        bus.rs  = 5'd8;
        bus.rt  = 5'd29;
        reset_n = 1'b1;
        tick();
        push("post_r8", SEL_RS, 32'h0);
        push("post_sp", SEL_RT, 32'd227);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
